// File: rtl/text_writer.sv
// text_writer: turns a stream of Unicode characters into tram writes for textmode.
// It handles cursor advance, CR/LF/BS, auto-wrap, hardware scroll (by moving
// scroll_offs) and screen clear.
//
// Optional feature macro: TEXT_WRITER_TAB_EN
//   defined   : 0x09 moves cur_x to the next multiple of 8 (newline if past the row)
//   undefined : 0x09 is an ordinary printable character
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   text_hres, text_vres   text geometry in characters (static while not busy)
//   in_valid/in_ready      character handshake
//   in_ucp                 character code point
//   in_colr_fg/bg          colour indices for the character (latched for scroll/clear fill)
//   clear                  clear-screen request pulse
//   tram_we/addr/din       tram write port, word = {bg, fg, 0..., ucp}
//   scroll_offs            tram address of the top-left visible character
//   cur_x, cur_y           cursor position
//   busy                   scroll or clear in progress
module text_writer #(
    parameter int unsigned ADDRW      = 11,
    parameter int unsigned CIDXW      = 4,
    parameter int unsigned TRAM_DEPTH = 2016,
    parameter int unsigned UCPW       = 21,
    parameter int unsigned WORD       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADDRW-1:0] text_hres,
    input  logic [ADDRW-1:0] text_vres,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [UCPW-1:0]  in_ucp,
    input  logic [CIDXW-1:0] in_colr_fg,
    input  logic [CIDXW-1:0] in_colr_bg,
    input  logic             clear,
    output logic             tram_we,
    output logic [ADDRW-1:0] tram_addr,
    output logic [WORD-1:0]  tram_din,
    output logic [ADDRW-1:0] scroll_offs,
    output logic [ADDRW-1:0] cur_x,
    output logic [ADDRW-1:0] cur_y,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, SCROLL, CLEAR} state_t;

    localparam logic [ADDRW:0]    DEPTH_W = (ADDRW+1)'(TRAM_DEPTH);
    localparam logic [ADDRW-1:0]  ONE     = ADDRW'(1);
    localparam logic [UCPW-1:0]   CH_LF   = UCPW'('h0A);
    localparam logic [UCPW-1:0]   CH_CR   = UCPW'('h0D);
    localparam logic [UCPW-1:0]   CH_BS   = UCPW'('h08);
    localparam logic [UCPW-1:0]   CH_SP   = UCPW'('h20);

    // Modular add for operands already below TRAM_DEPTH; one conditional subtract.
    function automatic logic [ADDRW-1:0] wrap_add(input logic [ADDRW-1:0] a,
                                                  input logic [ADDRW-1:0] b);
        logic [ADDRW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= DEPTH_W) s = s - DEPTH_W;
        return s[ADDRW-1:0];
    endfunction

    function automatic logic [WORD-1:0] make_word(input logic [CIDXW-1:0] bg,
                                                  input logic [CIDXW-1:0] fg,
                                                  input logic [UCPW-1:0]  ucp);
        logic [WORD-1:0] w;
        w = '0;
        w[WORD-1 -: CIDXW]       = bg;
        w[WORD-CIDXW-1 -: CIDXW] = fg;
        w[UCPW-1:0]              = ucp;
        return w;
    endfunction

    state_t           state, state_nxt;
    logic             clear_pend, pend_n;
    logic [ADDRW-1:0] line_base, lb_n;
    logic [ADDRW-1:0] fill_addr, fill_addr_n;
    logic [ADDRW-1:0] col, col_n, row, row_n;
    logic [CIDXW-1:0] fill_fg, fill_fg_n, fill_bg, fill_bg_n;
    logic [ADDRW-1:0] so_n, x_n, y_n;
    logic             we_n;
    logic [ADDRW-1:0] addr_n;
    logic [WORD-1:0]  din_n;
    logic             busy_n, ready_n;

    logic [ADDRW-1:0] hres_m1, vres_m1, lb_next, cell_addr;
    logic is_lf, is_cr, is_bs, is_tab, is_print, tab_wrap;
    logic at_eol, last_row, newline, accept, go_scroll, col_last, row_last;

    assign hres_m1   = text_hres - ONE;
    assign vres_m1   = text_vres - ONE;
    assign lb_next   = wrap_add(line_base, text_hres);
    assign cell_addr = wrap_add(line_base, cur_x);

    assign is_lf = (in_ucp == CH_LF);
    assign is_cr = (in_ucp == CH_CR);
    assign is_bs = (in_ucp == CH_BS);
`ifdef TEXT_WRITER_TAB_EN
    localparam logic [UCPW-1:0] CH_TAB = UCPW'('h09);
    logic [ADDRW:0] tab_x;
    assign is_tab   = (in_ucp == CH_TAB);
    assign tab_x    = ({1'b0, cur_x} | (ADDRW+1)'(7)) + (ADDRW+1)'(1);
    assign tab_wrap = (tab_x >= {1'b0, text_hres});
`else
    assign is_tab   = 1'b0;
    assign tab_wrap = 1'b0;
`endif
    assign is_print  = !(is_lf || is_cr || is_bs || is_tab);
    assign at_eol    = (cur_x == hres_m1);
    assign last_row  = !(cur_y < vres_m1);
    assign newline   = is_lf || (is_print && at_eol) || (is_tab && tab_wrap);
    // in_ready already implies IDLE with no pending clear; a same-cycle clear wins.
    assign accept    = in_valid && in_ready && !clear;
    assign go_scroll = accept && newline && last_row;
    assign col_last  = (col == hres_m1);
    assign row_last  = (row == vres_m1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clear || clear_pend) state_nxt = CLEAR;
                     else if (go_scroll)      state_nxt = SCROLL;
            SCROLL:  if (col_last)            state_nxt = IDLE;
            CLEAR:   if (col_last && row_last) state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    // Output / datapath next values. Fill writes are registered, so they trail
    // the SCROLL/CLEAR state by one cycle; a wrapping printable thus writes its
    // own cell before the first blank of the scroll.
    always_comb begin
        we_n        = 1'b0;
        addr_n      = tram_addr;
        din_n       = tram_din;
        so_n        = scroll_offs;
        lb_n        = line_base;
        x_n         = cur_x;
        y_n         = cur_y;
        fill_addr_n = fill_addr;
        col_n       = col;
        row_n       = row;
        fill_fg_n   = fill_fg;
        fill_bg_n   = fill_bg;
        pend_n      = clear_pend;
        case (state)
            IDLE: begin
                if (clear || clear_pend) begin
                    // The request that starts this clear is consumed here, so a
                    // clear arriving while it runs is queued for another pass.
                    pend_n      = 1'b0;
                    fill_addr_n = scroll_offs;
                    col_n       = '0;
                    row_n       = '0;
                    fill_fg_n   = in_colr_fg;
                    fill_bg_n   = in_colr_bg;
                end else if (accept) begin
                    if (is_cr) begin
                        x_n = '0;
                    end else if (is_bs) begin
                        if (cur_x != '0) x_n = cur_x - ONE;
`ifdef TEXT_WRITER_TAB_EN
                    end else if (is_tab) begin
                        if (!tab_wrap) x_n = tab_x[ADDRW-1:0];
`endif
                    end else if (is_print) begin
                        we_n   = 1'b1;
                        addr_n = cell_addr;
                        din_n  = make_word(in_colr_bg, in_colr_fg, in_ucp);
                        if (!at_eol) x_n = cur_x + ONE;
                    end
                    if (newline) begin
                        x_n  = '0;
                        lb_n = lb_next;
                        if (!last_row) begin
                            y_n = cur_y + ONE;
                        end else begin
                            so_n        = wrap_add(scroll_offs, text_hres);
                            fill_addr_n = lb_next;
                            col_n       = '0;
                            fill_fg_n   = in_colr_fg;
                            fill_bg_n   = in_colr_bg;
                        end
                    end
                end
            end
            SCROLL, CLEAR: begin
                we_n        = 1'b1;
                addr_n      = fill_addr;
                din_n       = make_word(fill_bg, fill_fg, CH_SP);
                fill_addr_n = wrap_add(fill_addr, ONE);
                pend_n      = clear_pend || clear;
                if (!col_last) begin
                    col_n = col + ONE;
                end else begin
                    col_n = '0;
                    if (state == CLEAR) begin
                        row_n = row + ONE;
                        if (row_last) begin
                            x_n  = '0;
                            y_n  = '0;
                            lb_n = scroll_offs;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    assign busy_n  = (state_nxt != IDLE);
    assign ready_n = (state_nxt == IDLE) && !pend_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tram_we     <= 1'b0;
            tram_addr   <= '0;
            tram_din    <= '0;
            scroll_offs <= '0;
            line_base   <= '0;
            cur_x       <= '0;
            cur_y       <= '0;
            fill_addr   <= '0;
            col         <= '0;
            row         <= '0;
            fill_fg     <= '0;
            fill_bg     <= '0;
            clear_pend  <= 1'b0;
            busy        <= 1'b0;
            in_ready    <= 1'b0;
        end else begin
            tram_we     <= we_n;
            tram_addr   <= addr_n;
            tram_din    <= din_n;
            scroll_offs <= so_n;
            line_base   <= lb_n;
            cur_x       <= x_n;
            cur_y       <= y_n;
            fill_addr   <= fill_addr_n;
            col         <= col_n;
            row         <= row_n;
            fill_fg     <= fill_fg_n;
            fill_bg     <= fill_bg_n;
            clear_pend  <= pend_n;
            busy        <= busy_n;
            in_ready    <= ready_n;
        end
    end

endmodule

// File: tb/tb_text_writer.sv
`timescale 1ns/1ps
module tb_text_writer;
    localparam int ADDRW = 11;
    localparam int CIDXW = 4;
    localparam int DEPTH = 2016;
    localparam int UCPW  = 21;
    localparam int WORD  = 32;
    localparam int HRES  = 84;
    localparam int VRES  = 24;

    logic             clk, rst;
    logic [ADDRW-1:0] text_hres, text_vres;
    logic             in_valid, in_ready;
    logic [UCPW-1:0]  in_ucp;
    logic [CIDXW-1:0] in_colr_fg, in_colr_bg;
    logic             clear;
    logic             tram_we;
    logic [ADDRW-1:0] tram_addr, scroll_offs, cur_x, cur_y;
    logic [WORD-1:0]  tram_din;
    logic             busy;

    text_writer #(.ADDRW(ADDRW), .CIDXW(CIDXW), .TRAM_DEPTH(DEPTH), .UCPW(UCPW), .WORD(WORD)) dut (
        .clk(clk), .rst(rst), .text_hres(text_hres), .text_vres(text_vres),
        .in_valid(in_valid), .in_ready(in_ready), .in_ucp(in_ucp),
        .in_colr_fg(in_colr_fg), .in_colr_bg(in_colr_bg), .clear(clear),
        .tram_we(tram_we), .tram_addr(tram_addr), .tram_din(tram_din),
        .scroll_offs(scroll_offs), .cur_x(cur_x), .cur_y(cur_y), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Behavioural model: screen geometry arithmetic plus queues of expected writes
    int m_x = 0, m_y = 0, m_so = 0;
    int exp_addr[$];
    logic [31:0] exp_din[$];
    int exp_busy[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic logic [31:0] tw(input int bg, input int fg, input int u);
        return {bg[3:0], fg[3:0], 3'b000, u[20:0]};
    endfunction

    task automatic model_newline(input int fg, input int bg);
        m_x = 0;
        if (m_y < VRES - 1) begin
            m_y++;
        end else begin
            m_so = (m_so + HRES) % DEPTH;
            for (int i = 0; i < HRES; i++) begin
                exp_addr.push_back((m_so + m_y * HRES + i) % DEPTH);
                exp_din.push_back(tw(bg, fg, 'h20));
            end
            exp_busy.push_back(HRES);
        end
    endtask

    task automatic model_char(input int u, input int fg, input int bg);
        int nx;
        case (u)
            'h0A: model_newline(fg, bg);
            'h0D: m_x = 0;
            'h08: if (m_x > 0) m_x--;
`ifdef TEXT_WRITER_TAB_EN
            'h09: begin
                nx = (m_x / 8 + 1) * 8;
                if (nx >= HRES) model_newline(fg, bg);
                else m_x = nx;
            end
`endif
            default: begin
                exp_addr.push_back((m_so + m_y * HRES + m_x) % DEPTH);
                exp_din.push_back(tw(bg, fg, u));
                if (m_x == HRES - 1) model_newline(fg, bg);
                else m_x++;
            end
        endcase
    endtask

    task automatic model_clear(input int fg, input int bg);
        for (int i = 0; i < HRES * VRES; i++) begin
            exp_addr.push_back((m_so + i) % DEPTH);
            exp_din.push_back(tw(bg, fg, 'h20));
        end
        exp_busy.push_back(HRES * VRES);
        m_x = 0;
        m_y = 0;
    endtask

    // Compare process: every write in order, cursor/scroll when ready, busy run lengths
    initial begin
        int run;
        int a;
        logic [31:0] d;
        run = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                run = 0;
            end else begin
                if (tram_we) begin
                    if (exp_addr.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: addr=%0d data=%0h, required no write", tram_addr, tram_din);
                    end else begin
                        a = exp_addr.pop_front();
                        d = exp_din.pop_front();
                        chk("write_addr", 64'(tram_addr), 64'(a));
                        chk("write_data", 64'(tram_din), 64'(d));
                    end
                end
                if (in_ready) begin
                    chk("cur_x", 64'(cur_x), 64'(m_x));
                    chk("cur_y", 64'(cur_y), 64'(m_y));
                    chk("scroll_offs", 64'(scroll_offs), 64'(m_so));
                    chk("busy_when_ready", 64'(busy), 64'(0));
                end
                if (busy) begin
                    run++;
                end else if (run > 0) begin
                    if (exp_busy.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_busy: busy run of %0d cycles, required none", run);
                    end else begin
                        chk("busy_len", 64'(run), 64'(exp_busy.pop_front()));
                    end
                    run = 0;
                end
            end
        end
    end

    // Drivers: always entered and left on a negedge
    task automatic send_char(input int u, input int fg, input int bg);
        int n;
        n = 0;
        while (!in_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
        end else begin
            in_valid   = 1'b1;
            in_ucp     = 21'(u);
            in_colr_fg = 4'(fg);
            in_colr_bg = 4'(bg);
            model_char(u, fg, bg);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!in_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s: in_ready=%0b after %0d cycles, required 1", name, in_ready, n);
        end
    endtask

    task automatic pulse_clear(input int fg, input int bg);
        clear      = 1'b1;
        in_colr_fg = 4'(fg);
        in_colr_bg = 4'(bg);
        model_clear(fg, bg);
        @(negedge clk);
        clear = 1'b0;
    endtask

    function automatic int rand_print();
        int u;
        u = int'($urandom & 32'h1F_FFFF);
        if (u == 'h08 || u == 'h09 || u == 'h0A || u == 'h0D) u = 'h41;
        return u;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int r, nclears, guard;
        rst        = 1'b1;
        text_hres  = ADDRW'(HRES);
        text_vres  = ADDRW'(VRES);
        in_valid   = 1'b0;
        in_ucp     = '0;
        in_colr_fg = '0;
        in_colr_bg = '0;
        clear      = 1'b0;
        #1;
        chk("reset_outputs", 64'({tram_we, tram_addr, tram_din, scroll_offs, cur_x, cur_y, busy, in_ready}), 64'(0));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_low_after_reset", 64'(in_ready), 64'(0));
        @(negedge clk);

        // Test 1: 'A' fg=7 bg=0 at origin
        send_char('h41, 7, 0);
        chk("t1_we", 64'(tram_we), 64'(1));
        chk("t1_addr", 64'(tram_addr), 64'(0));
        chk("t1_din", 64'(tram_din), 64'h0700_0041);
        chk("t1_cur_x", 64'(cur_x), 64'(1));

        // Test 2: rest of row 0 back-to-back, auto-wrap to (0,1)
        for (int i = 1; i < HRES; i++) send_char('h30 + (i % 10), 2, 1);
        chk("t2_cur_x", 64'(cur_x), 64'(0));
        chk("t2_cur_y", 64'(cur_y), 64'(1));
        chk("t2_busy", 64'(busy), 64'(0));

        // Test 3: cursor (5,23) with scroll_offs 0, then LF scrolls
        for (int i = 0; i < 22; i++) send_char('h0A, 3, 4);
        for (int i = 0; i < 5; i++) send_char('h61 + i, 5, 6);
        chk("t3_pre_x", 64'(cur_x), 64'(5));
        chk("t3_pre_y", 64'(cur_y), 64'(23));
        send_char('h0A, 9, 2);
        chk("t3_scroll_offs", 64'(scroll_offs), 64'(84));
        chk("t3_busy", 64'(busy), 64'(1));
        chk("t3_cur_x", 64'(cur_x), 64'(0));
        chk("t3_cur_y", 64'(cur_y), 64'(23));

        // Test 4: scroll until scroll_offs=1932, then one more wraps it to 0
        guard = 0;
        while (m_so != 1932 && guard < 30) begin
            send_char('h0A, 1, 8);
            guard++;
        end
        wait_ready("t4_ready");
        chk("t4_pre_offs", 64'(scroll_offs), 64'(1932));
        send_char('h0A, 12, 3);
        chk("t4_scroll_offs", 64'(scroll_offs), 64'(0));
        wait_ready("t4_done");

        // Test 5: clear pulsed while a scroll is running
        send_char('h0A, 4, 5);
        chk("t5_busy", 64'(busy), 64'(1));
        pulse_clear(6, 10);
        chk("t5_ready_low", 64'(in_ready), 64'(0));
        wait_ready("t5_done");
        chk("t5_cur_x", 64'(cur_x), 64'(0));
        chk("t5_cur_y", 64'(cur_y), 64'(0));

        // Test 6: BS at column 0, then TAB near the right edge
        send_char('h08, 1, 1);
        chk("t6_bs_x", 64'(cur_x), 64'(0));
`ifdef TEXT_WRITER_TAB_EN
        for (int i = 0; i < 81; i++) send_char('h5A, 2, 2);
        send_char('h09, 2, 2);
        chk("t6_tab_x", 64'(cur_x), 64'(0));
        chk("t6_tab_y", 64'(cur_y), 64'(1));
`else
        send_char('h09, 2, 2);
        chk("t6_tab_x", 64'(cur_x), 64'(1));
`endif

        // Random traffic
        nclears = 0;
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      send_char(rand_print(), $urandom_range(0, 15), $urandom_range(0, 15));
            else if (r < 80) send_char('h0A, $urandom_range(0, 15), $urandom_range(0, 15));
            else if (r < 85) send_char('h0D, 0, 0);
            else if (r < 90) send_char('h08, 0, 0);
            else if (r < 95) send_char('h09, $urandom_range(0, 15), $urandom_range(0, 15));
            else if (nclears < 2 && $urandom_range(0, 9) == 0) begin
                wait_ready("rand_clear_pre");
                pulse_clear($urandom_range(0, 15), $urandom_range(0, 15));
                wait_ready("rand_clear_done");
                nclears++;
            end else send_char(rand_print(), 15, 0);
        end

        // Reset in the middle of a clear
        guard = 0;
        while (m_so == 0 && guard < 30) begin
            send_char('h0A, 0, 0);
            guard++;
        end
        wait_ready("rst_pre");
        pulse_clear(3, 3);
        repeat (100) @(negedge clk);
        chk("rst_mid_we_before", 64'(tram_we), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_we", 64'(tram_we), 64'(0));
        chk("rst_mid_offs", 64'(scroll_offs), 64'(0));
        chk("rst_mid_busy", 64'(busy), 64'(0));
        chk("rst_mid_ready", 64'(in_ready), 64'(0));
        chk("rst_mid_cur", 64'({cur_x, cur_y}), 64'(0));
        exp_addr.delete();
        exp_din.delete();
        exp_busy.delete();
        m_x = 0;
        m_y = 0;
        m_so = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) send_char(rand_print(), $urandom_range(0, 15), $urandom_range(0, 15));
        repeat (3) @(negedge clk);
        chk("writes_drained", 64'(exp_addr.size()), 64'(0));
        chk("busy_runs_drained", 64'(exp_busy.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
